// File: rtl/rtc_pkg.sv
// Shared types and time arithmetic for the multi-alarm real-time clock.
// Includes the FSM encoding, the time-of-day struct and the 12-hour display helper.
package rtc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } fsm_t;

  localparam logic [4:0] MAX_HOUR = 5'd23;
  localparam logic [5:0] MAX_MIN  = 6'd59;
  localparam logic [5:0] MAX_SEC  = 6'd59;

  typedef struct packed {
    logic [4:0] hours;
    logic [5:0] mins;
    logic [5:0] secs;
  } time_t;

  typedef struct packed {
    logic       pm;
    logic [3:0] hours12;
  } disp_t;

  function automatic logic time_valid(input time_t t);
    return (t.hours <= MAX_HOUR) && (t.mins <= MAX_MIN) && (t.secs <= MAX_SEC);
  endfunction

  function automatic time_t next_time(input time_t t);
    time_t n;
    n = t;
    if (t.secs == MAX_SEC) begin
      n.secs = 6'd0;
      if (t.mins == MAX_MIN) begin
        n.mins = 6'd0;
        if (t.hours == MAX_HOUR) begin
          n.hours = 5'd0;
        end else begin
          n.hours = t.hours + 5'd1;
        end
      end else begin
        n.mins = t.mins + 6'd1;
      end
    end else begin
      n.secs = t.secs + 6'd1;
    end
    return n;
  endfunction

  function automatic disp_t to_12h(input logic [4:0] h);
    disp_t      d;
    logic [4:0] h_pm;
    h_pm = h - 5'd12;
    if (h == 5'd0) begin
      d = '{pm: 1'b0, hours12: 4'd12};
    end else if (h < 5'd12) begin
      d = '{pm: 1'b0, hours12: h[3:0]};
    end else if (h == 5'd12) begin
      d = '{pm: 1'b1, hours12: 4'd12};
    end else begin
      d = '{pm: 1'b1, hours12: h_pm[3:0]};
    end
    return d;
  endfunction

endpackage

// File: rtl/rtc_prescaler.sv
// Seconds prescaler: counts TICK_DIV clocks while running and flags the last one.
// Held at zero while stopped; a clear restarts the second boundary.
module rtc_prescaler #(
  parameter int TICK_DIV = 100000000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_r;

  assign tick = run && (count_r == LAST);

  // Clock-cycle counter with wrap, hold-at-zero and clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_r <= '0;
    end else if (clear || !run || tick) begin
      count_r <= '0;
    end else begin
      count_r <= count_r + CW'(1'b1);
    end
  end

endmodule

// File: rtl/rtc_alarm_multi.sv
// Time-of-day counter with validated loads, NUM_ALARMS alarm slots and a
// ring/snooze/dismiss buzzer FSM; also presents the time in 12-hour form.
module rtc_alarm_multi
  import rtc_pkg::*;
#(
  parameter int TICK_DIV    = 100000000,
  parameter int NUM_ALARMS  = 4,
  parameter int RING_SECS   = 30,
  parameter int SNOOZE_MINS = 5,
  localparam int IW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  load_time,
  input  logic [4:0]            load_hours,
  input  logic [5:0]            load_mins,
  input  logic [5:0]            load_secs,
  input  logic                  alarm_wr,
  input  logic [IW-1:0]         alarm_idx,
  input  logic [4:0]            alarm_hours,
  input  logic [5:0]            alarm_mins,
  input  logic [5:0]            alarm_secs,
  input  logic [NUM_ALARMS-1:0] alarm_en,
  input  logic                  snooze,
  input  logic                  dismiss,
  output logic [4:0]            hours,
  output logic [5:0]            mins,
  output logic [5:0]            secs,
  output logic [3:0]            disp_hours,
  output logic                  pm,
  output logic                  sec_pulse,
  output logic                  buzzer,
  output logic [IW-1:0]         ring_idx,
  output logic                  load_err
);

  localparam logic [7:0]  RING_LOAD = 8'(RING_SECS);
  localparam logic [11:0] SNZ_LOAD  = 12'(SNOOZE_MINS * 60);

  time_t         time_r;
  time_t         next_time_s;
  time_t         load_val_s;
  time_t         alarm_val_s;
  time_t         slot_r [NUM_ALARMS];
  logic          tick_s;
  logic          load_ok_s;
  logic          alarm_ok_s;
  logic          load_acc_s;
  logic          adv_s;
  logic          match_s;
  logic [IW-1:0] match_idx_s;
  logic          en_ring_s;
  fsm_t          state_r;
  fsm_t          state_n_s;
  logic [7:0]    ring_cnt_r;
  logic [7:0]    ring_cnt_n_s;
  logic [11:0]   snz_cnt_r;
  logic [11:0]   snz_cnt_n_s;
  logic [IW-1:0] ring_idx_r;
  logic [IW-1:0] ring_idx_n_s;
  logic          sec_pulse_r;
  logic          load_err_r;
  disp_t         disp_s;

  assign load_val_s  = '{hours: load_hours, mins: load_mins, secs: load_secs};
  assign alarm_val_s = '{hours: alarm_hours, mins: alarm_mins, secs: alarm_secs};
  assign load_ok_s   = time_valid(load_val_s);
  assign alarm_ok_s  = time_valid(alarm_val_s) && ({1'b0, alarm_idx} < (IW+1)'(NUM_ALARMS));
  assign load_acc_s  = load_time && load_ok_s;
  // An accepted load swallows a coincident tick.
  assign adv_s       = tick_s && !load_acc_s;
  assign next_time_s = next_time(time_r);
  assign en_ring_s   = alarm_en[ring_idx_r];

  rtc_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .clear (load_acc_s),
    .tick  (tick_s)
  );

  // Time-of-day register: load wins over advance.
  always_ff @(posedge clk) begin
    if (!reset) begin
      time_r <= '0;
    end else if (load_acc_s) begin
      time_r <= load_val_s;
    end else if (adv_s) begin
      time_r <= next_time_s;
    end
  end

  // Alarm slot storage.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        slot_r[i] <= '0;
      end
    end else if (alarm_wr && alarm_ok_s) begin
      slot_r[alarm_idx] <= alarm_val_s;
    end
  end

  // Matcher against the post-increment time; the descending scan leaves the lowest hit.
  always_comb begin
    match_s     = 1'b0;
    match_idx_s = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      match_s     = match_s | (alarm_en[i] && (slot_r[i] == next_time_s));
      match_idx_s = (alarm_en[i] && (slot_r[i] == next_time_s)) ? IW'(i) : match_idx_s;
    end
  end

  // Buzzer FSM next-state: dismiss > enable-drop > snooze > tick countdown.
  always_comb begin
    state_n_s    = state_r;
    ring_cnt_n_s = ring_cnt_r;
    snz_cnt_n_s  = snz_cnt_r;
    ring_idx_n_s = ring_idx_r;
    case (state_r)
      IDLE: begin
        if (adv_s && match_s) begin
          state_n_s    = RING;
          ring_cnt_n_s = RING_LOAD;
          ring_idx_n_s = match_idx_s;
        end else begin
          state_n_s = IDLE;
        end
      end
      RING: begin
        if (dismiss || !en_ring_s) begin
          state_n_s = IDLE;
        end else if (snooze) begin
          state_n_s   = SNOOZE;
          snz_cnt_n_s = SNZ_LOAD;
        end else if (adv_s) begin
          if (ring_cnt_r == 8'd1) begin
            state_n_s = IDLE;
          end else begin
            ring_cnt_n_s = ring_cnt_r - 8'd1;
          end
        end else begin
          state_n_s = RING;
        end
      end
      SNOOZE: begin
        if (dismiss || !en_ring_s) begin
          state_n_s = IDLE;
        end else if (adv_s) begin
          if (snz_cnt_r == 12'd1) begin
            state_n_s    = RING;
            ring_cnt_n_s = RING_LOAD;
          end else begin
            snz_cnt_n_s = snz_cnt_r - 12'd1;
          end
        end else begin
          state_n_s = SNOOZE;
        end
      end
      default: begin
        state_n_s = IDLE;
      end
    endcase
  end

  // FSM state, timers and status pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= IDLE;
      ring_cnt_r  <= 8'd0;
      snz_cnt_r   <= 12'd0;
      ring_idx_r  <= '0;
      sec_pulse_r <= 1'b0;
      load_err_r  <= 1'b0;
    end else begin
      state_r     <= state_n_s;
      ring_cnt_r  <= ring_cnt_n_s;
      snz_cnt_r   <= snz_cnt_n_s;
      ring_idx_r  <= ring_idx_n_s;
      sec_pulse_r <= adv_s;
      load_err_r  <= (load_time && !load_ok_s) || (alarm_wr && !alarm_ok_s);
    end
  end

  assign disp_s     = to_12h(time_r.hours);
  assign hours      = time_r.hours;
  assign mins       = time_r.mins;
  assign secs       = time_r.secs;
  assign disp_hours = disp_s.hours12;
  assign pm         = disp_s.pm;
  assign sec_pulse  = sec_pulse_r;
  assign buzzer     = (state_r == RING);
  assign ring_idx   = ring_idx_r;
  assign load_err   = load_err_r;

endmodule

// File: tb/tb_rtc_alarm_multi.sv
// Directed bench for rtc_alarm_multi with a seconds-of-day reference model
// checked every cycle, plus hand-computed literal checkpoints.
module tb_rtc_alarm_multi;

  localparam int TD = 4;
  localparam int NA = 4;
  localparam int RS = 3;
  localparam int SM = 1;

  logic       clk = 1'b0;
  logic       reset, run, load_time, alarm_wr, snooze, dismiss;
  logic [4:0] load_hours, alarm_hours;
  logic [5:0] load_mins, load_secs, alarm_mins, alarm_secs;
  logic [1:0] alarm_idx;
  logic [3:0] alarm_en;
  logic [4:0] hours;
  logic [5:0] mins, secs;
  logic [3:0] disp_hours;
  logic       pm, sec_pulse, buzzer, load_err;
  logic [1:0] ring_idx;

  int vectors = 0;
  int miscompares = 0;
  bit checking = 1'b0;
  int pulse_cnt = 0;

  // Reference model: time as seconds of day, mode 0 idle / 1 ring / 2 snooze.
  int m_tod, m_pre, m_mode, m_ring_left, m_snz_left, m_ring_idx;
  bit m_sec_pulse, m_load_err;
  int m_slot [NA];

  always #5 clk = ~clk;

  rtc_alarm_multi #(.TICK_DIV(TD), .NUM_ALARMS(NA), .RING_SECS(RS), .SNOOZE_MINS(SM)) dut (
    .clk(clk), .reset(reset), .run(run), .load_time(load_time),
    .load_hours(load_hours), .load_mins(load_mins), .load_secs(load_secs),
    .alarm_wr(alarm_wr), .alarm_idx(alarm_idx), .alarm_hours(alarm_hours),
    .alarm_mins(alarm_mins), .alarm_secs(alarm_secs), .alarm_en(alarm_en),
    .snooze(snooze), .dismiss(dismiss), .hours(hours), .mins(mins), .secs(secs),
    .disp_hours(disp_hours), .pm(pm), .sec_pulse(sec_pulse), .buzzer(buzzer),
    .ring_idx(ring_idx), .load_err(load_err)
  );

  task automatic model_step();
    bit tok, aok, acc, tick, adv;
    int hit;
    if (!reset) begin
      m_tod = 0; m_pre = 0; m_mode = 0; m_ring_left = 0; m_snz_left = 0;
      m_ring_idx = 0; m_sec_pulse = 0; m_load_err = 0;
      for (int i = 0; i < NA; i++) m_slot[i] = 0;
      return;
    end
    tok  = (load_hours < 24) && (load_mins < 60) && (load_secs < 60);
    aok  = (alarm_hours < 24) && (alarm_mins < 60) && (alarm_secs < 60);
    acc  = load_time && tok;
    tick = run && (m_pre == TD - 1);
    adv  = tick && !acc;
    m_pre = (acc || !run || tick) ? 0 : m_pre + 1;
    if (acc) m_tod = load_hours * 3600 + load_mins * 60 + load_secs;
    else if (adv) m_tod = (m_tod + 1) % 86400;
    hit = -1;
    if (adv)
      for (int i = NA - 1; i >= 0; i--)
        if (alarm_en[i] && m_slot[i] == m_tod) hit = i;
    if (m_mode == 0) begin
      if (hit >= 0) begin m_mode = 1; m_ring_left = RS; m_ring_idx = hit; end
    end else if (dismiss || !alarm_en[m_ring_idx]) begin
      m_mode = 0;
    end else if (m_mode == 1) begin
      if (snooze) begin m_mode = 2; m_snz_left = SM * 60; end
      else if (adv) begin
        if (m_ring_left == 1) m_mode = 0;
        else m_ring_left--;
      end
    end else if (adv) begin
      if (m_snz_left == 1) begin m_mode = 1; m_ring_left = RS; end
      else m_snz_left--;
    end
    if (alarm_wr && aok) m_slot[alarm_idx] = alarm_hours * 3600 + alarm_mins * 60 + alarm_secs;
    m_load_err  = (load_time && !tok) || (alarm_wr && !aok);
    m_sec_pulse = adv;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    int h, m, s, d;
    bit p;
    if (checking) begin
      h = m_tod / 3600; m = (m_tod / 60) % 60; s = m_tod % 60;
      d = (h % 12 == 0) ? 12 : h % 12;
      p = (h >= 12);
      vectors++;
      if (hours !== 5'(h) || mins !== 6'(m) || secs !== 6'(s) || disp_hours !== 4'(d) ||
          pm !== p || sec_pulse !== m_sec_pulse || buzzer !== (m_mode == 1) ||
          ring_idx !== 2'(m_ring_idx) || load_err !== m_load_err) begin
        miscompares++;
        $display("FAIL model t=%0t: got %0d:%0d:%0d d%0d pm%0b sp%0b bz%0b ri%0d le%0b want %0d:%0d:%0d d%0d pm%0b sp%0b bz%0b ri%0d le%0b",
                 $time, hours, mins, secs, disp_hours, pm, sec_pulse, buzzer, ring_idx, load_err,
                 h, m, s, d, p, m_sec_pulse, (m_mode == 1), m_ring_idx, m_load_err);
      end
      if (sec_pulse === 1'b1) pulse_cnt++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      #1;
      load_time = 1'b0; alarm_wr = 1'b0; snooze = 1'b0; dismiss = 1'b0;
    end
  endtask

  task automatic do_load(input int h, input int m, input int s);
    load_hours = 5'(h); load_mins = 6'(m); load_secs = 6'(s); load_time = 1'b1;
    step(1);
  endtask

  task automatic do_alarm(input int idx, input int h, input int m, input int s);
    alarm_idx = 2'(idx); alarm_hours = 5'(h); alarm_mins = 6'(m); alarm_secs = 6'(s);
    alarm_wr = 1'b1;
    step(1);
  endtask

  task automatic wait_buzz(input bit lvl, input int maxc, input string name);
    int k = 0;
    while (buzzer !== lvl && k < maxc) begin step(1); k++; end
    check(name, int'(buzzer), int'(lvl));
  endtask

  task automatic wait_secs(input int target, input int maxc, input string name);
    int k = 0;
    while (int'(secs) != target && k < maxc) begin step(1); k++; end
    check(name, int'(secs), target);
  endtask

  initial begin
    reset = 1'b0; run = 1'b0; load_time = 1'b0; alarm_wr = 1'b0; snooze = 1'b0; dismiss = 1'b0;
    load_hours = 5'd0; load_mins = 6'd0; load_secs = 6'd0;
    alarm_idx = 2'd0; alarm_hours = 5'd0; alarm_mins = 6'd0; alarm_secs = 6'd0; alarm_en = 4'd0;
    step(2);
    checking = 1'b1;
    step(1);
    check("rst_hours", int'(hours), 0);
    check("rst_buzzer", int'(buzzer), 0);
    reset = 1'b1;

    // Rollover across midnight and sec_pulse cadence.
    do_load(23, 59, 58);
    check("load_hours", int'(hours), 23);
    check("load_secs", int'(secs), 58);
    pulse_cnt = 0;
    run = 1'b1;
    step(8);
    run = 1'b0;
    step(1);
    check("roll_hms", int'({hours, mins, secs}), 0);
    check("roll_disp", int'(disp_hours), 12);
    check("roll_pm", int'(pm), 0);
    check("pulse_cnt", pulse_cnt, 2);
    check("model_tod", m_tod, 0);

    // Rejected loads.
    do_load(24, 0, 0);
    check("bad_load_err", int'(load_err), 1);
    check("bad_load_hours", int'(hours), 0);
    step(1);
    check("load_err_clear", int'(load_err), 0);
    do_alarm(0, 0, 60, 0);
    check("bad_alarm_err", int'(load_err), 1);
    step(1);

    // Single alarm ring and auto-stop.
    do_alarm(2, 0, 0, 5);
    alarm_en = 4'b0100;
    do_load(0, 0, 0);
    run = 1'b1;
    wait_buzz(1'b1, 40, "t3_rise");
    check("t3_rise_secs", int'(secs), 5);
    check("t3_ring_idx", int'(ring_idx), 2);
    wait_buzz(1'b0, 40, "t3_fall");
    check("t3_fall_secs", int'(secs), 8);
    alarm_en = 4'b0000;
    run = 1'b0;

    // Priority of simultaneous matches and snooze expiry.
    do_alarm(1, 0, 0, 5);
    do_alarm(3, 0, 0, 5);
    alarm_en = 4'b1010;
    do_load(0, 0, 0);
    run = 1'b1;
    wait_buzz(1'b1, 40, "t4_rise");
    check("t4_ring_idx", int'(ring_idx), 1);
    wait_secs(6, 20, "t4_secs6");
    snooze = 1'b1;
    step(1);
    check("t4_snoozed", int'(buzzer), 0);
    wait_buzz(1'b1, 300, "t4_rering");
    check("t4_rering_mins", int'(mins), 1);
    check("t4_rering_secs", int'(secs), 6);

    // Dismiss beats snooze; enable drop in SNOOZE returns to IDLE.
    dismiss = 1'b1; snooze = 1'b1;
    step(1);
    check("t5_dismiss", int'(buzzer), 0);
    step(8);
    check("t5_stay_idle", int'(buzzer), 0);
    do_load(0, 0, 0);
    wait_buzz(1'b1, 40, "t5_rise");
    snooze = 1'b1;
    step(1);
    check("t5_snoozed", int'(buzzer), 0);
    step(8);
    alarm_en = 4'b1000;
    step(1);
    alarm_en = 4'b1010;
    step(260);
    check("t5_drop_idle", int'(buzzer), 0);

    // Load coincident with a tick, then 12-hour display corners.
    for (int k = 0; k < 8 && m_pre != TD - 1; k++) step(1);
    do_load(12, 0, 0);
    check("t6_hours", int'(hours), 12);
    check("t6_disp", int'(disp_hours), 12);
    check("t6_pm", int'(pm), 1);
    step(3);
    check("t6_no_inc", int'(secs), 0);
    step(1);
    check("t6_first_inc", int'(secs), 1);
    run = 1'b0;
    do_load(0, 0, 0);
    check("disp_h0", int'(disp_hours), 12);
    check("pm_h0", int'(pm), 0);
    do_load(13, 0, 0);
    check("disp_h13", int'(disp_hours), 1);
    check("pm_h13", int'(pm), 1);
    do_load(23, 59, 59);
    check("disp_h23", int'(disp_hours), 11);

    // Reset while ringing.
    do_load(0, 0, 3);
    run = 1'b1;
    wait_buzz(1'b1, 40, "t6_ring");
    check("t6_ring_idx", int'(ring_idx), 1);
    reset = 1'b0;
    step(1);
    check("rst_ring_buzzer", int'(buzzer), 0);
    check("rst_ring_idx", int'(ring_idx), 0);
    check("rst_ring_secs", int'(secs), 0);
    reset = 1'b1;
    run = 1'b0;
    step(2);

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rtc_alarm_multi.md
Name: rtc_alarm_multi

Overview:
- Parametrised successor of the team's single-alarm time-of-day counter.
- Contains an internal seconds prescaler, validated time load and NUM_ALARMS independently enabled alarms.
- A ring/snooze/dismiss FSM drives the buzzer; time is also output in 12-hour display form.
- Sits between the board clock and the seven-segment/buzzer drivers.

Parameters:
TICK_DIV, 100000000, clk cycles per second; must be >= 2
NUM_ALARMS, 4, number of alarm slots; 1..8
RING_SECS, 30, seconds buzzer rings before auto-stop; 1..255
SNOOZE_MINS, 5, snooze length in minutes; 1..59

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
run  in  1  1 = time advances; 0 = time frozen, prescaler held at 0
load_time  in  1  one-cycle strobe: load load_hours/mins/secs
load_hours  in  5  0..23
load_mins  in  6  0..59
load_secs  in  6  0..59
alarm_wr  in  1  one-cycle strobe: write slot alarm_idx
alarm_idx  in  $clog2(NUM_ALARMS) (min 1)  slot to write
alarm_hours  in  5  0..23
alarm_mins  in  6  0..59
alarm_secs  in  6  0..59
alarm_en  in  NUM_ALARMS  per-slot enable, level, sampled every cycle
snooze  in  1  one-cycle strobe
dismiss  in  1  one-cycle strobe
hours  out  5  0..23
mins  out  6  0..59
secs  out  6  0..59
disp_hours  out  4  12-hour form, 1..12
pm  out  1  1 when hours >= 12
sec_pulse  out  1  one-cycle pulse on each time advance
buzzer  out  1  1 while in RING
ring_idx  out  $clog2(NUM_ALARMS) (min 1)  slot that caused the current RING/SNOOZE
load_err  out  1  one-cycle pulse: rejected load_time or alarm_wr

Behaviour:
Reset (reset == 0 at a clk edge):
- Time regs and prescaler are 0; sec_pulse, buzzer, load_err, ring_idx are 0.
- All alarm slots are 00:00:00 and the FSM is IDLE.
- Alarm slots are registered state; there are no combinational latches.

Prescaler:
- While run == 1, it counts 0..TICK_DIV-1.
- The tick fires in the cycle the count is TICK_DIV-1; the count then wraps to 0.

Time advance on tick:
- secs increments; 59 -> 0 with mins carry.
- mins 59 -> 0 with hours carry.
- hours 23 -> 0.
- sec_pulse is registered and is high the cycle after the edge that updates the time.

load_time:
- Any field out of range: the load is ignored and load_err pulses the next cycle.
- Otherwise all three fields load at that edge and the prescaler clears to 0.
- load_time has priority over a tick in the same cycle; the tick is dropped.
- A load never triggers an alarm.

alarm_wr:
- An out-of-range field rejects the write and pulses load_err.
- A write to a slot during RING/SNOOZE does not change the FSM.

disp_hours/pm: combinational from hours.
- hours 0 -> 12, pm = 0.
- hours 1..11 -> hours, pm = 0.
- hours 12 -> 12, pm = 1.
- hours 13..23 -> hours-12, pm = 1.

Match:
- Evaluated only on a tick, comparing the next time value (post-increment) with each enabled slot.
- On a match, buzzer rises on the same edge that time becomes the alarm time. There is no off-by-one offset.
- Multiple simultaneous matches: the lowest index wins and sets ring_idx.
- Matches are ignored while the FSM is in RING or SNOOZE.

FSM states:
- IDLE: on a match -> RING, with ring_cnt = RING_SECS.
- RING (buzzer = 1):
  - dismiss -> IDLE.
  - else snooze -> SNOOZE, with snz_cnt = SNOOZE_MINS*60.
  - else each tick decrements ring_cnt; at 1 -> IDLE (auto-stop, no re-arm).
- SNOOZE (buzzer = 0):
  - dismiss -> IDLE.
  - Each tick decrements snz_cnt; at 1 -> RING with ring_cnt reloaded.
  - snooze in SNOOZE is ignored.
- If alarm_en[ring_idx] drops in RING or SNOOZE -> IDLE next cycle.
- Priority: dismiss > enable-drop > snooze > tick count.

run = 0:
- The FSM timers freeze because they are tick-driven.
- dismiss and snooze still act.

Reset mid-RING/SNOOZE: returns to IDLE and clears buzzer on that edge.

Counter widths:
- ring_cnt is 8 bits.
- snz_cnt is 12 bits (<= 3540).

Decomposition:
- Package rtc_pkg:
  - fsm enum {IDLE, RING, SNOOZE}
  - constants MAX_HOUR = 23, MAX_MIN = 59, MAX_SEC = 59
  - time_t struct {hours[4:0], mins[5:0], secs[5:0]}
  - function next_time(time_t)
  - function to_12h
- One sub-module is natural: rtc_prescaler (TICK_DIV counter, run/clear inputs, tick output).
- Alarm slots, the matcher and the FSM stay in the top module.

Test Plan:
1. TICK_DIV = 4; load 23:59:58, run = 1 -> after 2 ticks (8 cycles) time is 00:00:00; sec_pulse is high once per 4 cycles.
2. Load hours = 24 -> time unchanged, load_err pulses one cycle. Separately, alarm_wr with mins = 60 -> slot unchanged, load_err pulses.
3. Slot 2 = 00:00:05 enabled; load 00:00:00 -> buzzer rises on the edge secs becomes 5; ring_idx = 2. With RING_SECS = 3, buzzer falls when secs becomes 8.
4. Slots 1 and 3 both = 00:00:05, both enabled -> ring_idx = 1. Snooze at secs 6 -> buzzer 0. With SNOOZE_MINS = 1, buzzer rises again at 00:01:06.
5. RING, then dismiss and snooze in the same cycle -> IDLE, buzzer 0. Separately, alarm_en[ring_idx] cleared during SNOOZE -> IDLE next cycle.
6. load_time coincident with a tick -> loaded value held with no increment, prescaler 0. Then hours 0 / 12 / 13 -> disp_hours 12 / 12 / 1 with pm 0 / 1 / 1. Reset low in RING -> all outputs 0 next edge.
